// File: rtl/sequence_detector_moore.sv
// ============================================================================
// sequence_detector_moore - serial Moore pattern detector (default 1011).
// Optional match counter enabled by defining SEQ_DET_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sequence_detector_moore #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1011,
  parameter bit                       OVERLAP       = 1'b1,
  parameter int                       COUNT_WIDTH   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] match_count
`endif
);

  localparam int            STATE_W   = $clog2(PATTERN_WIDTH + 1);
  localparam int            NUM_CODES = 1 << STATE_W;
  localparam logic [STATE_W-1:0] S0   = '0;
  localparam logic [STATE_W-1:0] SN   = STATE_W'(PATTERN_WIDTH);

  // KMP transition evaluated at elaboration: longest prefix of PATTERN that
  // is a suffix of (prefix of length k, then b), capped below a full
  // N+1-bit string so the match state itself is never re-entered trivially.
  function automatic int delta(input int k, input bit b);
    bit [16:0] s;
    int        k_eff;
    int        len;
    int        best;
    bit        ok;
    k_eff = (k == PATTERN_WIDTH && !OVERLAP) ? 0 : k;
    len   = k_eff + 1;
    s     = '0;
    for (int i = 0; i < 17; i++) begin
      if (i < k_eff) s[i] = PATTERN[PATTERN_WIDTH-1-i];
    end
    s[k_eff] = b;
    best = 0;
    for (int j = 1; j <= PATTERN_WIDTH; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < PATTERN_WIDTH; i++) begin
          if (i < j && s[len-j+i] != PATTERN[PATTERN_WIDTH-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [STATE_W-1:0] next_on0 [NUM_CODES];
  logic [STATE_W-1:0] next_on1 [NUM_CODES];
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;

  for (genvar c = 0; c < NUM_CODES; c++) begin : g_table
    if (c <= PATTERN_WIDTH) begin : g_valid
      localparam int NEXT0 = delta(c, 1'b0);
      localparam int NEXT1 = delta(c, 1'b1);
      assign next_on0[c] = STATE_W'(NEXT0);
      assign next_on1[c] = STATE_W'(NEXT1);
    end else begin : g_unused
      // Illegal encodings recover to the idle state on the next edge.
      assign next_on0[c] = S0;
      assign next_on1[c] = S0;
    end
  end

  assign next_state = sequence_in ? next_on1[state] : next_on0[state];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S0;
      detector_out <= 1'b0;
    end else begin
      state        <= next_state;
      detector_out <= (next_state == SN);
    end
  end

`ifdef SEQ_DET_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      match_count <= '0;
    end else if (next_state == SN) begin
      match_count <= match_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sequence_detector_moore.sv
// ============================================================================
// tb_sequence_detector_moore - scoreboard bench for the 1011 detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sequence_detector_moore;

  logic clock;
  logic reset;
  logic sequence_in;
  logic det_ov;
  logic det_no;
`ifdef SEQ_DET_COUNT_EN
  logic [1:0] cnt_ov;
  logic [1:0] cnt_no;
`endif

  int n_cmp;
  int n_err;

  typedef struct {
    bit det_ov;
    bit det_no;
    int cnt;
  } exp_t;

  exp_t sb[$];

  logic [3:0] hist;
  int         len_ov;
  int         len_no;
  int         cnt;

  sequence_detector_moore #(
    .PATTERN_WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_WIDTH(2)
  ) dut_ov (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .detector_out(det_ov)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (cnt_ov)
`endif
  );

  sequence_detector_moore #(
    .PATTERN_WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_WIDTH(2)
  ) dut_no (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .detector_out(det_no)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (cnt_no)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one bit (or a reset cycle), predict, then compare after the edge.
  task automatic step(input bit b, input bit r);
    exp_t e;
    bit   m_ov;
    bit   m_no;
    @(negedge clock);
    sequence_in = b;
    reset       = r;
    if (r) begin
      hist   = 4'b0000;
      len_ov = 0;
      len_no = 0;
      cnt    = 0;
      m_ov   = 1'b0;
      m_no   = 1'b0;
    end else begin
      hist   = {hist[2:0], b};
      len_ov = (len_ov < 4) ? len_ov + 1 : 4;
      len_no = (len_no < 4) ? len_no + 1 : 4;
      m_ov   = (len_ov >= 4) && (hist == 4'b1011);
      m_no   = (len_no >= 4) && (hist == 4'b1011);
      if (m_no) len_no = 0;
      if (m_ov) cnt = (cnt + 1) % 4;
    end
    e.det_ov = m_ov;
    e.det_no = m_no;
    e.cnt    = cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("det_ov", int'(det_ov), int'(e.det_ov));
    check("det_no", int'(det_no), int'(e.det_no));
`ifdef SEQ_DET_COUNT_EN
    check("cnt_ov", int'(cnt_ov), e.cnt);
`endif
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    hist        = 4'b0000;
    len_ov      = 0;
    len_no      = 0;
    cnt         = 0;
    reset       = 1'b1;
    sequence_in = 1'b0;

    // Reset held three clocks while the input toggles.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    stream(32'b01011, 5);
    step(1'b0, 1'b1);
    stream(32'b1011011, 7);
    step(1'b0, 1'b1);
    stream(32'b1111110000, 10);
    step(1'b0, 1'b1);
    stream(32'b101011, 6);
    step(1'b0, 1'b1);

    // Partial progress is lost across a mid-sequence reset.
    stream(32'b101, 3);
    step(1'b1, 1'b1);
    stream(32'b1, 1);
    stream(32'b1011, 4);
    step(1'b0, 1'b1);

    // Counter wrap: five back-to-back matches.
    stream(32'h0000_BBBB, 16);
    stream(32'b1011, 4);
    step(1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    step(1'b1, 1'b1);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
